// File: rtl/instr_rom_pipelined.sv
// Pipelined instruction ROM with base-address decode, error flags and a
// sequential boot-load port that streams the program image in at run time.
module instr_rom_pipelined #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_BITS    = 6,
    parameter logic [31:0]           BASE_ADDRESS = 32'h0,
    parameter int unsigned           LATENCY      = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req,
    input  logic [31:0]           rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            rd_err,
    output logic                  rd_busy,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_done
);

    localparam int unsigned           DEPTH    = 1 << ADDR_BITS;
    localparam int unsigned           TAG_W    = 30 - ADDR_BITS;
    localparam logic [TAG_W-1:0]      BASE_TAG = BASE_ADDRESS[TAG_W-1:0];
    localparam logic [ADDR_BITS-1:0]  LAST_IDX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } ld_state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    ld_state_e             state_q, state_d;
    logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
    logic                  mem_we;

    // Load FSM
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + ADDR_BITS'(1);
                    if (ptr_q == LAST_IDX) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Program memory is deliberately left out of reset so a reset keeps the image.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[ptr_q] <= ld_data;
    end

    assign rd_busy = (state_q == ST_LOAD);
    assign ld_done = (state_q == ST_DONE);

    logic [ADDR_BITS-1:0]  rd_idx;
    logic                  unaligned, miss;
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic [1:0]            s1_err_q, s1_err_d;

    always_comb begin
        rd_idx     = rd_addr[ADDR_BITS+1:2];
        unaligned  = |rd_addr[1:0];
        miss       = (rd_addr[31:ADDR_BITS+2] != BASE_TAG);
        s1_valid_d = rd_req && (state_q == ST_IDLE);
        s1_err_d   = s1_valid_d ? {miss, unaligned} : 2'b00;
        s1_data_d  = NOP_WORD;
        if (s1_valid_d && !miss && !unaligned) s1_data_d = mem_q[rd_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= NOP_WORD;
            s1_err_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_err_q   <= s1_err_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (s1_valid_d && unaligned)
            $warning("instr_rom_pipelined: unaligned fetch addr=%h at time %0t", rd_addr, $time);
    end
`endif

    // Any LATENCY other than 2 is treated as single-cycle.
    generate
        if (LATENCY == 2) begin : g_lat2
            logic                  s2_valid_q;
            logic [DATA_WIDTH-1:0] s2_data_q;
            logic [1:0]            s2_err_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= NOP_WORD;
                    s2_err_q   <= '0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    s2_data_q  <= s1_data_q;
                    s2_err_q   <= s1_err_q;
                end
            end

            assign rd_valid = s2_valid_q;
            assign rd_data  = s2_data_q;
            assign rd_err   = s2_err_q;
        end else begin : g_lat1
            assign rd_valid = s1_valid_q;
            assign rd_data  = s1_data_q;
            assign rd_err   = s1_err_q;
        end
    endgenerate

endmodule
